// File: rtl/detector_pkg.sv
// Shared definitions for the parking direction decoder: FSM state encoding
// and the up/down command codes understood by the occupancy counter.
package detector_pkg;

  // Decoder states; REPOSO must stay 0 and FALLA 7 for the counter side.
  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    E1     = 3'd1,
    E2     = 3'd2,
    E3     = 3'd3,
    S1     = 3'd4,
    S2     = 3'd5,
    S3     = 3'd6,
    FALLA  = 3'd7
  } estado_t;

  // Counter command codes, bit0 = Z0 (up), bit1 = Z1 (down); 2'b11 unused.
  localparam logic [1:0] Z_MANTENER = 2'b00;
  localparam logic [1:0] Z_SUBIR    = 2'b01;
  localparam logic [1:0] Z_BAJAR    = 2'b10;

endpackage

// File: rtl/antirrebote.sv
// One light-barrier input: 2-FF synchroniser followed, when the macro
// DETECTOR_ANTIRREBOTE_EN is defined, by a stability filter that only
// accepts a new level after DEB_CICLOS consecutive identical samples.
module antirrebote #(
  parameter int DEB_CICLOS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Only 4-bit stability counters are provided.
  if (DEB_CICLOS < 2 || DEB_CICLOS > 15) begin : g_rango_invalido
    $error("antirrebote: DEB_CICLOS must be within 2..15");
  end

  logic [1:0] sync_q, sync_d;

  // Shift the asynchronous sensor into the clock domain.
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // Synchroniser register.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= sync_d;
  end

`ifdef DETECTOR_ANTIRREBOTE_EN
  logic [3:0] cnt_q, cnt_d;
  logic       out_q, out_d;

  // Count how long the synchronised level has differed from the output.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (sync_q[1] == out_q) begin
      cnt_d = 4'd0;
    end else if (cnt_q == 4'(DEB_CICLOS - 1)) begin
      out_d = sync_q[1];
      cnt_d = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Stability counter and filtered output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign q = out_q;
`else
  assign q = sync_q[1];
`endif

endmodule

// File: rtl/detector_sentido.sv
// Vehicle direction decoder: tracks the A(outer)/B(inner) barrier pattern,
// issues one-cycle count-up (Z0) / count-down (Z1) commands, rejects entries
// when the lot is full and drives the entry barrier.
// Optional input debounce is enabled with the macro DETECTOR_ANTIRREBOTE_EN.
module detector_sentido
  import detector_pkg::*;
#(
  parameter int DEB_CICLOS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic lleno,
  output logic Z0,
  output logic Z1,
  output logic barrera,
  output logic rechazo,
  output logic error
);

  logic       as_s, bs_s;
  logic [1:0] sens;

  estado_t    estado_q, estado_d;
  logic [1:0] cmd_q, cmd_d;
  logic       rechazo_q, rechazo_d;
  logic       error_q, error_d;
  logic       barrera_q, barrera_d;

  antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_ant_a (
    .clk (clk),
    .rst (rst),
    .d   (a),
    .q   (as_s)
  );

  antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_ant_b (
    .clk (clk),
    .rst (rst),
    .d   (b),
    .q   (bs_s)
  );

  assign sens = {as_s, bs_s};

  // Next-state and registered-output decode of the sensor pattern.
  always_comb begin
    estado_d  = estado_q;
    cmd_d     = Z_MANTENER;
    rechazo_d = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (sens == 2'b10)      estado_d = E1;
        else if (sens == 2'b01) estado_d = S1;
        else if (sens == 2'b11) estado_d = FALLA;
      end
      E1: begin
        if (sens == 2'b11)      estado_d = E2;
        else if (sens == 2'b00) estado_d = REPOSO;
        else if (sens == 2'b01) estado_d = FALLA;
      end
      E2: begin
        if (sens == 2'b01)      estado_d = E3;
        else if (sens == 2'b10) estado_d = E1;
        else if (sens == 2'b00) estado_d = FALLA;
      end
      E3: begin
        if (sens == 2'b00) begin
          estado_d = REPOSO;
          // lleno only matters in the completion cycle itself.
          if (lleno) rechazo_d = 1'b1;
          else       cmd_d     = Z_SUBIR;
        end else if (sens == 2'b11) begin
          estado_d = E2;
        end else if (sens == 2'b10) begin
          estado_d = FALLA;
        end
      end
      S1: begin
        if (sens == 2'b11)      estado_d = S2;
        else if (sens == 2'b00) estado_d = REPOSO;
        else if (sens == 2'b10) estado_d = FALLA;
      end
      S2: begin
        if (sens == 2'b10)      estado_d = S3;
        else if (sens == 2'b01) estado_d = S1;
        else if (sens == 2'b00) estado_d = FALLA;
      end
      S3: begin
        if (sens == 2'b00) begin
          estado_d = REPOSO;
          // The counter saturates at 0 by itself, so exit always counts down.
          cmd_d    = Z_BAJAR;
        end else if (sens == 2'b11) begin
          estado_d = S2;
        end else if (sens == 2'b01) begin
          estado_d = FALLA;
        end
      end
      FALLA: begin
        if (sens == 2'b00) estado_d = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
    // Registered copy of "next state is FALLA" equals "state is FALLA".
    error_d   = (estado_d == FALLA);
    barrera_d = ~lleno;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= REPOSO;
      cmd_q     <= Z_MANTENER;
      rechazo_q <= 1'b0;
      error_q   <= 1'b0;
      barrera_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cmd_q     <= cmd_d;
      rechazo_q <= rechazo_d;
      error_q   <= error_d;
      barrera_q <= barrera_d;
    end
  end

  assign Z0      = cmd_q[0];
  assign Z1      = cmd_q[1];
  assign rechazo = rechazo_q;
  assign error   = error_q;
  assign barrera = barrera_q;

endmodule

// File: tb/tb_detector_sentido.sv
// Directed bench for detector_sentido with a behavioural 3-bit occupancy
// counter wired to Z0/Z1 and feeding lleno back.
module tb_detector_sentido;
  import detector_pkg::*;

  localparam int DEB = 4;
`ifdef DETECTOR_ANTIRREBOTE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam int H = LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic lleno;
  logic Z0, Z1, barrera, rechazo, error;

  logic [2:0] occ = 3'd0;
  logic       ld = 1'b0;
  logic [2:0] ld_val = 3'd0;

  int n_z0 = 0;
  int n_z1 = 0;
  int n_rech = 0;
  int n_both = 0;
  int total = 0;
  int bad = 0;
  int z0_s, z1_s, r_s;

  detector_sentido #(.DEB_CICLOS(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .lleno   (lleno),
    .Z0      (Z0),
    .Z1      (Z1),
    .barrera (barrera),
    .rechazo (rechazo),
    .error   (error)
  );

  always #5 clk = ~clk;

  assign lleno = (occ == 3'd7);

  always @(posedge clk) begin
    if (ld)                      occ <= ld_val;
    else if (Z0 && occ != 3'd7)  occ <= occ + 3'd1;
    else if (Z1 && occ != 3'd0)  occ <= occ - 3'd1;
    if (Z0)        n_z0   <= n_z0 + 1;
    if (Z1)        n_z1   <= n_z1 + 1;
    if (rechazo)   n_rech <= n_rech + 1;
    if (Z0 && Z1)  n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    {a, b} = ab;
    step(n);
  endtask

  task automatic preload(input logic [2:0] v);
    ld = 1'b1;
    ld_val = v;
    step(1);
    ld = 1'b0;
  endtask

  task automatic snap();
    z0_s = n_z0;
    z1_s = n_z1;
    r_s  = n_rech;
  endtask

  initial begin
    // reset state
    step(3);
    chk("rst_Z0", int'(Z0), 0);
    chk("rst_Z1", int'(Z1), 0);
    chk("rst_rechazo", int'(rechazo), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_barrera", int'(barrera), 0);
    chk("rst_state", int'(dut.estado_q), int'(REPOSO));
    rst = 1'b0;
    step(2);
    chk("barrera_libre", int'(barrera), 1);

    // entry with free lot, exact pulse timing
    snap();
    hold(2'b10, H);
    hold(2'b11, H);
    hold(2'b01, H);
    {a, b} = 2'b00;
    step(LAT - 1);
    chk("entry_Z0_early", int'(Z0), 0);
    step(1);
    chk("entry_Z0_pulse", int'(Z0), 1);
    step(1);
    chk("entry_Z0_after", int'(Z0), 0);
    chk("entry_occ", int'(occ), 1);
    chk("entry_n_z0", n_z0 - z0_s, 1);
    chk("entry_n_z1", n_z1 - z1_s, 0);

    // exit at occupancy 3
    preload(3'd3);
    snap();
    hold(2'b01, H);
    hold(2'b11, H);
    hold(2'b10, H);
    hold(2'b00, H + 2);
    chk("exit_n_z1", n_z1 - z1_s, 1);
    chk("exit_n_z0", n_z0 - z0_s, 0);
    chk("exit_occ", int'(occ), 2);

    // entry abort (backs out)
    snap();
    hold(2'b10, H);
    hold(2'b11, H);
    hold(2'b10, H);
    hold(2'b00, H + 2);
    chk("abort_n_z0", n_z0 - z0_s, 0);
    chk("abort_n_z1", n_z1 - z1_s, 0);
    chk("abort_state", int'(dut.estado_q), int'(REPOSO));

    // full lot
    preload(3'd7);
    step(2);
    chk("full_barrera", int'(barrera), 0);
    snap();
    hold(2'b10, H);
    hold(2'b11, H);
    hold(2'b01, H);
    hold(2'b00, H + 2);
    chk("full_rechazo", n_rech - r_s, 1);
    chk("full_n_z0", n_z0 - z0_s, 0);
    chk("full_occ", int'(occ), 7);

    // illegal jump from idle
    preload(3'd0);
    snap();
    hold(2'b11, H);
    chk("illegal_error", int'(error), 1);
    chk("illegal_state", int'(dut.estado_q), int'(FALLA));
    hold(2'b00, LAT - 1);
    chk("illegal_error_hold", int'(error), 1);
    step(1);
    chk("illegal_error_clear", int'(error), 0);
    step(2);
    hold(2'b10, H);
    hold(2'b11, H);
    hold(2'b01, H);
    hold(2'b00, H + 2);
    chk("illegal_then_entry_z0", n_z0 - z0_s, 1);
    chk("illegal_then_entry_rech", n_rech - r_s, 0);

    // reset while in E2
    snap();
    hold(2'b10, H);
    hold(2'b11, H);
    chk("e2_state", int'(dut.estado_q), int'(E2));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    {a, b} = 2'b00;
    chk("rste2_state", int'(dut.estado_q), int'(REPOSO));
    chk("rste2_Z0", int'(Z0), 0);
    chk("rste2_Z1", int'(Z1), 0);
    chk("rste2_rechazo", int'(rechazo), 0);
    chk("rste2_error", int'(error), 0);
    chk("rste2_barrera", int'(barrera), 0);
    step(2 * H);
    chk("rste2_no_pulse", (n_z0 - z0_s) + (n_z1 - z1_s) + (n_rech - r_s), 0);
    chk("rste2_state_late", int'(dut.estado_q), int'(REPOSO));

`ifdef DETECTOR_ANTIRREBOTE_EN
    // short glitch on a is filtered
    hold(2'b10, 2);
    hold(2'b00, H + 4);
    chk("glitch_state", int'(dut.estado_q), int'(REPOSO));
`endif

    chk("never_both", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
